// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state encoding and the per-digit add-3 / blank-scan rules.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [BCD_DIGIT_W-1:0] digit_adj(
        input logic [BCD_DIGIT_W-1:0] d
    );
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // One step of the top-down leading-zero scan.
    function automatic logic blank_next(
        input logic                   above_blank,
        input logic [BCD_DIGIT_W-1:0] d
    );
        return above_blank && (d == 4'd0);
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between the converter and its user.
// master drives the request, slave is the converter.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 8
);
    logic                  iStart;
    logic [BIN_W-1:0]      iNum;
    logic                  oBusy;
    logic                  oValid;
    logic [4*DIGITS-1:0]   oBcd;
    logic [DIGITS-1:0]     oBlank;
    logic                  oOvf;

    modport master (
        output iStart, iNum,
        input  oBusy, oValid, oBcd, oBlank, oOvf
    );

    modport slave (
        input  iStart, iNum,
        output oBusy, oValid, oBcd, oBlank, oOvf
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// Combinational add-3 cell for one BCD digit of the double-dabble shifter.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);
    assign q = digit_adj(d);
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter, one shift per clock, with
// leading-zero blank mask and overflow flag for the digit displays.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 8
) (
    input  logic iClk,
    input  logic iRst,
    bin_to_bcd_seq_if.slave bus
);
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    state_t            state_q, state_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]  acc_q, acc_d;
    logic [BCD_W-1:0]  acc_adj;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_out;

    logic [BCD_W-1:0]  bcd_q;
    logic [DIGITS-1:0] blank_q, blank_c;
    logic              ovf_out_q;
    logic              valid_q;
    logic              z;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .q (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        load_out = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.iStart) begin
                    bin_d   = bus.iNum;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {acc_d, bin_d} = {acc_adj, bin_q} << 1;
                ovf_d = ovf_q | acc_adj[BCD_W-1];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = DONE;
            end
            DONE: begin
                load_out = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Overflow shows every digit, so the mask is cleared entirely.
    always_comb begin
        blank_c = '0;
        z       = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            z = blank_next(z, acc_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
            if (i > 0)
                blank_c[i] = z & ~ovf_q;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            blank_q   <= BLANK_RST;
            ovf_out_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            valid_q <= load_out;
            if (load_out) begin
                bcd_q     <= acc_q;
                blank_q   <= blank_c;
                ovf_out_q <= ovf_q;
            end
        end
    end

    assign bus.oBusy  = (state_q != IDLE) || valid_q;
    assign bus.oValid = valid_q;
    assign bus.oBcd   = bcd_q;
    assign bus.oBlank = blank_q;
    assign bus.oOvf   = ovf_out_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq with an arithmetic reference model.
module tb_bin_to_bcd_seq;
    localparam int BIN_W  = 32;
    localparam int DIGITS = 8;

    logic iClk = 1'b0;
    logic iRst = 1'b1;

    bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus)
    );

    always #10 iClk = ~iClk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decimal digits by plain division.
    function automatic logic [31:0] ref_bcd(input longint v);
        logic [31:0] r = '0;
        longint x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input longint v);
        return v >= 64'd100000000;
    endfunction

    function automatic logic [7:0] ref_blank(input longint v);
        logic [7:0] b = '0;
        longint x = v % 64'd100000000;
        if (ref_ovf(v)) return '0;
        for (int i = 1; i < DIGITS; i++) begin
            longint p = 1;
            for (int j = 0; j < i; j++) p = p * 10;
            b[i] = (x < p);
        end
        return b;
    endfunction

    // Cycle-level model driven from acceptance time and value only.
    longint     cyc = 0;
    bit         m_active = 0;
    longint     m_vedge = 0;
    longint     m_num = 0;
    bit         m_valid = 0;
    bit         m_busy = 0;
    logic [31:0] m_bcd = '0;
    logic [7:0] m_blank = 8'hFE;
    bit         m_ovf = 0;
    bit         chk_en = 0;

    always @(posedge iClk) begin
        bit acc;
        bit fin;
        cyc <= cyc + 1;
        if (iRst) begin
            m_active <= 0;
            m_valid  <= 0;
            m_busy   <= 0;
            m_bcd    <= '0;
            m_blank  <= 8'hFE;
            m_ovf    <= 0;
        end else begin
            fin = m_active && (cyc == m_vedge);
            acc = bus.iStart && (!m_active || cyc > m_vedge);
            m_valid <= fin;
            m_busy  <= acc || (m_active && cyc <= m_vedge);
            if (fin) begin
                m_bcd   <= ref_bcd(m_num);
                m_blank <= ref_blank(m_num);
                m_ovf   <= ref_ovf(m_num);
            end
            if (acc) begin
                m_active <= 1;
                m_vedge  <= cyc + BIN_W + 1;
                m_num    <= longint'(bus.iNum);
            end
        end
    end

    always @(negedge iClk) begin
        if (chk_en) begin
            chk("mdl_valid", bus.oValid, m_valid);
            chk("mdl_busy", bus.oBusy, m_busy);
            chk("mdl_bcd", bus.oBcd, m_bcd);
            chk("mdl_blank", bus.oBlank, m_blank);
            chk("mdl_ovf", bus.oOvf, m_ovf);
        end
    end

    task automatic run(input logic [31:0] num, input logic [31:0] eb,
                       input logic [7:0] ebl, input logic eo);
        int n = 1;
        int busy_n = 0;
        bit got = 0;
        @(negedge iClk);
        bus.iStart = 1'b1;
        bus.iNum   = num;
        @(negedge iClk);
        bus.iStart = 1'b0;
        while (n <= 40 && !got) begin
            if (bus.oBusy) busy_n++;
            if (bus.oValid) got = 1;
            else begin
                @(negedge iClk);
                n++;
            end
        end
        chk("valid_seen", got, 1);
        chk("latency", n, BIN_W + 2);
        chk("busy_cycles", busy_n, BIN_W + 2);
        chk("lit_bcd", bus.oBcd, eb);
        chk("lit_blank", bus.oBlank, ebl);
        chk("lit_ovf", bus.oOvf, eo);
        @(negedge iClk);
        chk("valid_pulse", bus.oValid, 0);
        chk("idle_after", bus.oBusy, 0);
        chk("hold_bcd", bus.oBcd, eb);
    endtask

    initial begin
        int v;
        bus.iStart = 1'b0;
        bus.iNum   = '0;
        repeat (2) @(negedge iClk);
        iRst = 1'b0;
        chk("rst_bcd", bus.oBcd, 0);
        chk("rst_blank", bus.oBlank, 8'hFE);
        chk("rst_busy", bus.oBusy, 0);
        chk("rst_valid", bus.oValid, 0);
        chk("rst_ovf", bus.oOvf, 0);
        chk_en = 1;

        run(32'd0,          32'h00000000, 8'b11111110, 1'b0);
        run(32'd1234,       32'h00001234, 8'b11110000, 1'b0);
        run(32'd99999999,   32'h99999999, 8'b00000000, 1'b0);
        run(32'd100000000,  32'h00000000, 8'b00000000, 1'b1);
        run(32'd4294967295, 32'h94967295, 8'b00000000, 1'b1);
        run(32'd7,          32'h00000007, 8'b11111110, 1'b0);

        // Second request while busy must be ignored.
        @(negedge iClk);
        bus.iStart = 1'b1;
        bus.iNum   = 32'd5678;
        @(negedge iClk);
        bus.iStart = 1'b0;
        repeat (9) @(negedge iClk);
        bus.iStart = 1'b1;
        bus.iNum   = 32'd42;
        @(negedge iClk);
        bus.iStart = 1'b0;
        v = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.oValid) begin
                v++;
                chk("ign_bcd", bus.oBcd, 32'h00005678);
            end
            @(negedge iClk);
        end
        chk("ign_pulses", v, 1);

        // Reset mid-conversion aborts with no result.
        bus.iStart = 1'b1;
        bus.iNum   = 32'd777;
        @(negedge iClk);
        bus.iStart = 1'b0;
        repeat (14) @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        v = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.oValid) v++;
            @(negedge iClk);
        end
        chk("abort_pulses", v, 0);
        chk("abort_bcd", bus.oBcd, 0);
        chk("abort_blank", bus.oBlank, 8'hFE);
        chk("abort_busy", bus.oBusy, 0);
        run(32'd777, 32'h00000777, 8'b11111000, 1'b0);

        // Held iStart is re-accepted in the oValid cycle.
        bus.iStart = 1'b1;
        bus.iNum   = 32'd1234;
        v = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge iClk);
            if (bus.oValid) v++;
        end
        bus.iStart = 1'b0;
        chk("b2b_pulses", v, 2);
        repeat (40) @(negedge iClk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
